// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encoding and the default performance-counter width.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hc_state_t;

  localparam int DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use interlock, EX redirect, fetch wait and
// halt-drain control for the IF/ID, ID/EX and EX/MEM registers.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | normal issue; redirect > load-use > halt > fetch wait
// ST_DRAIN  | halt accepted; inject bubbles while older instructions retire
// ST_HALTED | pipeline frozen until resume
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES  = 3,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               id_rs1_addr,
  input  logic [4:0]               id_rs2_addr,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_halt_req,
  input  logic [4:0]               ex_rd_addr,
  input  logic                     ex_mem_read,
  input  logic                     ex_redirect,
  input  logic                     imem_ready,
  input  logic                     resume,
  output logic                     pc_stall,
  output logic                     pc_redirect,
  output logic                     if_id_stall,
  output logic                     if_id_flush,
  output logic                     id_ex_stall,
  output logic                     id_ex_flush,
  output logic                     ex_mem_flush,
  output logic                     halted,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic [COUNTER_WIDTH-1:0] flush_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  hc_state_t          state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic               load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                     (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pc_stall      = 1'b0;
    pc_redirect   = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      unique case (state)
        ST_RUN: begin
          if (ex_redirect) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (id_halt_req) begin
            // The halt instruction itself moves on into ID/EX.
            pc_stall      = 1'b1;
            if_id_flush   = 1'b1;
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = '0;
          end else if (!imem_ready) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt     = ST_HALTED;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
          end
        end
        ST_HALTED: begin
          halted       = 1'b1;
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          if (resume) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt     = ST_RUN;
          drain_cnt_nxt = '0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_count (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_count (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_redirect),
    .count (flush_count)
  );

endmodule
